// File: rtl/muxn_pkg.sv
// -----------------------------------------------------------------------------
// muxn_pkg
// Shared constants and helpers for the muxn_scan N:1 multiplexer.
//   MaxInputs   - largest supported channel count
//   MaxSelWidth - select width needed for MaxInputs channels
//   sel_t       - select type sized for MaxInputs
//   sel_width() - select width for n channels, never less than one bit
// -----------------------------------------------------------------------------
package muxn_pkg;

    localparam int MaxInputs   = 16;
    localparam int MaxSelWidth = 4;

    typedef logic [MaxSelWidth-1:0] sel_t;

    // A 1-channel or 2-channel mux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : muxn_pkg

// File: rtl/muxn_tree.sv
// -----------------------------------------------------------------------------
// muxn_tree
// Purely combinational N:1 multiplexer built as a linear chain of 2:1 cells.
// Stage 0 passes channel 0; stage k picks channel k when sel_i == k, otherwise
// it forwards the previous stage. The last stage is channel[sel_i] for every
// legal select value.
// Ports:
//   ch_i   NumInputs*Width  packed channels, channel k at [k*Width +: Width]
//   sel_i  SelWidth         channel select
//   y_o    Width            selected channel
// -----------------------------------------------------------------------------
module muxn_tree
    import muxn_pkg::*;
#(
    parameter int NumInputs = 3,
    parameter int Width     = 1,
    parameter int SelWidth  = sel_width(NumInputs)
) (
    input  logic [NumInputs*Width-1:0] ch_i,
    input  logic [SelWidth-1:0]        sel_i,
    output logic [Width-1:0]           y_o
);

    // NOTE: always_comb uses blocking assignments and gives y_o a value before
    // any conditional update, so every path assigns it and no latch is inferred.
    always_comb begin
        y_o = ch_i[0 +: Width];
        for (int k = 1; k < NumInputs; k++) begin
            if (sel_i == SelWidth'(k)) begin
                y_o = ch_i[k*Width +: Width];
            end
        end
    end

endmodule : muxn_tree

// File: rtl/muxn_scan.sv
// -----------------------------------------------------------------------------
// muxn_scan
// Parametrised N:1 multiplexer of Width-bit channels with a registered select,
// a registered output and an optional auto-scan sequencer.
// Build option: define MUXN_SCAN_EN to build the scan incrementer/wrap logic;
// without it scan_i is unused and wrap_o is tied low.
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   i_i          channel data, channel k at [k*Width +: Width]
//   sel_i        select value to load
//   sel_valid_i  load sel_i this cycle (out-of-range values are rejected)
//   scan_i       advance the select by one, wrapping at NumInputs-1
//   y_o          registered selected channel (uses the select before update)
//   sel_o        current select register
//   wrap_o       one-cycle pulse when the scan wraps to channel 0
//   err_o        one-cycle pulse when an out-of-range load is rejected
// -----------------------------------------------------------------------------
module muxn_scan
    import muxn_pkg::*;
#(
    parameter  int NumInputs = 3,
    parameter  int Width     = 1,
    localparam int SelWidth  = sel_width(NumInputs)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumInputs*Width-1:0] i_i,
    input  logic [SelWidth-1:0]        sel_i,
    input  logic                       sel_valid_i,
    input  logic                       scan_i,
    output logic [Width-1:0]           y_o,
    output logic [SelWidth-1:0]        sel_o,
    output logic                       wrap_o,
    output logic                       err_o
);

    logic [SelWidth-1:0] sel_q, sel_d;
    logic [Width-1:0]    y_q, y_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic                load_ok;

    // Mux is driven by the current select, so a load shows on y_o one edge
    // after it shows on sel_o.
    muxn_tree #(
        .NumInputs (NumInputs),
        .Width     (Width),
        .SelWidth  (SelWidth)
    ) u_tree (
        .ch_i  (i_i),
        .sel_i (sel_q),
        .y_o   (y_d)
    );

    // Extra leading bit so NumInputs itself fits when it is a power of two.
    assign load_ok = ({1'b0, sel_i} < (SelWidth+1)'(NumInputs));

    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (sel_valid_i) begin
            // Any load request, accepted or rejected, blocks scanning.
            if (load_ok) begin
                sel_d = sel_i;
            end else begin
                err_d = 1'b1;
            end
        end
`ifdef MUXN_SCAN_EN
        else if (scan_i) begin
            if (sel_q == SelWidth'(NumInputs-1)) begin
                sel_d  = '0;
                wrap_d = 1'b1;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end
`endif
    end

`ifndef MUXN_SCAN_EN
    logic unused_scan;
    assign unused_scan = scan_i;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs; reset here is synchronous, tested inside the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sel_q  <= '0;
            y_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign y_o    = y_q;
    assign sel_o  = sel_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;

endmodule : muxn_scan

// File: doc/muxn_scan.md
# muxn_scan

Parametrised N:1 multiplexer of W-bit channels with a registered select, a registered output and an optional auto-scan sequencer. It generalises the fixed 3:1 merged-cell mux chain to arbitrary channel count and data width. It is used wherever a board-level design time-multiplexes several buses onto one, e.g. display digit scanning or sampling sensor lines, built from 2:1 mux cells plus flip-flop cells.

## Interface

Parameters:
- NumInputs, 3, number of channels; legal range 2..16.
- Width, 1, bits per channel.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_ni  input  1  reset; synchronous and active-low.
- i_i  input  NumInputs*Width  channel data; channel k occupies bits [k*Width +: Width].
- sel_i  input  SelWidth  select value to load; SelWidth = max(1, $clog2(NumInputs)).
- sel_valid_i  input  1  load sel_i into the select register this cycle.
- scan_i  input  1  advance the select register by one this cycle; ignored when the scan feature is compiled out.
- y_o  output  Width  registered selected channel.
- sel_o  output  SelWidth  current select register value (sel_q).
- wrap_o  output  1  one-cycle pulse when the scan wraps from NumInputs-1 to 0.
- err_o  output  1  one-cycle pulse when an out-of-range load is rejected.

## Operation

- State:
  - sel_q (SelWidth).
  - y_q (Width), driving y_o.
  - wrap_q and err_q, driving wrap_o and err_o.
- Reset (rst_ni low at a rising edge):
  - sel_q=0, y_o=0, wrap_o=0, err_o=0.
  - Reset asserted mid-scan discards all state; no wrap_o or err_o pulse is generated on that edge.
- Every non-reset cycle, y_q <= channel[sel_q]. The mux uses the current (old) sel_q, not the value being loaded.
- Select update priority, evaluated per cycle:
  1. sel_valid_i=1 and sel_i < NumInputs: sel_q <= sel_i. A simultaneous scan_i is ignored and wrap_o stays 0.
  2. sel_valid_i=1 and sel_i >= NumInputs: sel_q is unchanged and err_o pulses for one cycle. scan_i in the same cycle is also ignored, so a rejected load still blocks scanning.
  3. scan_i=1 (feature compiled in), with sel_q < NumInputs-1: sel_q <= sel_q+1.
  4. scan_i=1 (feature compiled in), with sel_q = NumInputs-1: sel_q <= 0 and wrap_o pulses for one cycle.
  5. Otherwise sel_q holds.
- sel_q never holds a value >= NumInputs. When NumInputs is a power of two, the out-of-range branch is unreachable.
- No handshake: every input is sampled every cycle, with no back-pressure.

## Timing

- Data latency: y_o(t+1) = channel[sel_q(t)] of i_i(t). This is one cycle.
- Select latency:
  - sel_valid_i at edge t updates sel_o after t.
  - y_o shows the new channel after edge t+1, two cycles after the load request.
- wrap_o and err_o are registered. Each asserts for the single cycle following the triggering edge.
- Continuous scan_i=1 gives channel period NumInputs cycles, with wrap_o every NumInputs cycles.
- No combinational path from any input to any output.

## Configuration

- MUXN_SCAN_EN defined:
  - scan_i increments and wraps sel_q as described above.
  - wrap_o is generated.
- MUXN_SCAN_EN undefined:
  - No incrementer or wrap logic is built, and scan_i is unused.
  - wrap_o is tied to 0.
  - Select changes only via sel_valid_i.
  - All other behaviour is identical.

## Structure

- Package muxn_pkg:
  - MaxInputs = 16.
  - Function sel_width(n), returning max(1, $clog2(n)).
  - Typedef for the select type at MaxInputs width.
- Sub-module muxn_tree: purely combinational N:1 mux.
  - Built as a linear chain of 2:1 mux cells.
  - Stage k selects between channel k and the output of the previous stage.
  - Selects are decoded from sel_q, one per stage.
  - Output is channel[sel] for every legal sel.
- muxn_scan holds only the registers, the priority logic and an instance of muxn_tree.

## Test plan

- Reset: NumInputs=3, Width=4, drive i_i={4'hC,4'hB,4'hA}, hold rst_ni=0 for 3 cycles -> y_o=0, sel_o=0, wrap_o=0, err_o=0. One cycle after release, y_o=4'hA.
- Load: sel_i=2 with sel_valid_i=1 for one cycle -> sel_o=2 after that edge, and y_o=4'hC one edge later.
- Scan wrap (MUXN_SCAN_EN): hold scan_i=1 from sel_o=0 -> sel_o sequence 1,2,0,1. wrap_o=1 only in the cycle sel_o returns to 0. y_o follows A,B,C,A one cycle behind sel_o.
- Priority: at sel_o=2, assert scan_i=1 together with sel_valid_i=1, sel_i=1 -> sel_o=1 and wrap_o=0.
- Out-of-range: sel_o=1, sel_valid_i=1, sel_i=3, scan_i=1 -> sel_o stays 1, err_o pulses for 1 cycle, y_o stays 4'hB.
- Mid-scan reset plus compiled-out build:
  - With scan_i=1 at sel_o=2, pull rst_ni=0 -> sel_o=0 and no wrap_o pulse.
  - Without MUXN_SCAN_EN, scan_i=1 for 5 cycles -> sel_o constant and wrap_o always 0.
